// File: rtl/symmetry_stats_pkg.sv
// symmetry_stats_pkg: shared encodings for the symmetry statistics stage.
// Readback selects, FSM states and detector limits.
package symmetry_stats_pkg;

  localparam logic [1:0] SEL_SYM  = 2'd0;
  localparam logic [1:0] SEL_MIS  = 2'd1;
  localparam logic [1:0] SEL_RUN  = 2'd2;
  localparam logic [1:0] SEL_STAT = 2'd3;

  localparam logic [2:0] MAX_MISMATCH = 3'd4;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/symmetry_stats_sat_add8.sv
// sat_add8: 8-bit accumulator add with a 3-bit addend.
// Clamps at 255 and flags any carry out.
module sat_add8 (
  input  logic [7:0] a,
  input  logic [2:0] b,
  output logic [7:0] sum,
  output logic       sat
);

  logic [8:0] full;

  // Wide add, clamp on carry
  always_comb begin
    full = {1'b0, a} + {6'b0, b};
    sat  = full[8];
    sum  = full[8] ? 8'hFF : full[7:0];
  end

endmodule

// File: rtl/symmetry_stats.sv
// symmetry_stats: windowed counts of symmetric words, mismatches, runs.
// Window results snapshot into registers read via rd_sel/rd_data.
module symmetry_stats
  import symmetry_stats_pkg::*;
#(
  parameter int WINDOW = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_sym,
  input  logic [2:0] in_mismatch,
  input  logic       clear,
  input  logic [1:0] rd_sel,
  output logic [7:0] rd_data,
  output logic       win_done,
  output logic       busy
);

  localparam logic [7:0] LAST = 8'(WINDOW - 1);

  state_t     state_q, state_d;
  logic [7:0] n_samp, n_sym, mis_sum;
  logic [7:0] run_cur, run_max;
  logic [7:0] snap_sym, snap_mis, snap_run;
  logic       snap_valid, sat, err;

  logic       accept, last, chk_err;
  logic [7:0] mis_nx, sym_nx, run_inc, max_nx;
  logic       sat_hit;

  sat_add8 u_add (
    .a   (mis_sum),
    .b   (in_mismatch),
    .sum (mis_nx),
    .sat (sat_hit)
  );

  // Per-sample next values and consistency check
  always_comb begin
    accept  = in_valid & ~clear;
    last    = accept & (n_samp == LAST);
    run_inc = run_cur + 8'd1;
    sym_nx  = in_sym ? n_sym + 8'd1 : n_sym;
    max_nx  = run_max;
    if (in_sym && run_inc > run_max)
      max_nx = run_inc;
    chk_err = (in_sym && in_mismatch != 3'd0)
            || (!in_sym && in_mismatch == 3'd0)
            || (in_mismatch > MAX_MISMATCH);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (clear)
      state_d = IDLE;
    else if (accept)
      state_d = last ? IDLE : ACCUM;
  end

  assign busy = (state_q == ACCUM);

  // Live accumulation, window snapshot and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_samp     <= '0;
      n_sym      <= '0;
      mis_sum    <= '0;
      run_cur    <= '0;
      run_max    <= '0;
      snap_sym   <= '0;
      snap_mis   <= '0;
      snap_run   <= '0;
      snap_valid <= 1'b0;
      sat        <= 1'b0;
      err        <= 1'b0;
    end else if (clear) begin
      n_samp     <= '0;
      n_sym      <= '0;
      mis_sum    <= '0;
      run_cur    <= '0;
      run_max    <= '0;
      snap_sym   <= '0;
      snap_mis   <= '0;
      snap_run   <= '0;
      snap_valid <= 1'b0;
      sat        <= 1'b0;
      err        <= 1'b0;
    end else if (accept) begin
      if (sat_hit) sat <= 1'b1;
      if (chk_err) err <= 1'b1;
      if (last) begin
        snap_sym   <= sym_nx;
        snap_mis   <= mis_nx;
        snap_run   <= max_nx;
        snap_valid <= 1'b1;
        n_samp     <= '0;
        n_sym      <= '0;
        mis_sum    <= '0;
        run_cur    <= '0;
        run_max    <= '0;
      end else begin
        n_samp  <= n_samp + 8'd1;
        n_sym   <= sym_nx;
        mis_sum <= mis_nx;
        run_cur <= in_sym ? run_inc : 8'd0;
        run_max <= max_nx;
      end
    end
  end

  // Registered completion pulse and readback mux
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_done <= 1'b0;
      rd_data  <= '0;
    end else begin
      win_done <= last;
      unique case (rd_sel)
        SEL_SYM:  rd_data <= snap_sym;
        SEL_MIS:  rd_data <= snap_mis;
        SEL_RUN:  rd_data <= snap_run;
        SEL_STAT: rd_data <= {4'b0, err, sat, busy, snap_valid};
        default:  rd_data <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_symmetry_stats.sv
// tb_symmetry_stats: directed scoreboard bench for symmetry_stats.
// Two instances: WINDOW=16 for most scenarios, WINDOW=255 for saturation.
module tb_symmetry_stats;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_sym, clear;
  logic [2:0] in_mismatch;
  logic [1:0] rd_sel;
  logic [7:0] rd_data, rd_data2;
  logic       win_done, win_done2, busy, busy2;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [7:0] sym;
    logic [7:0] mis;
    logic [7:0] run;
  } exp_t;

  exp_t sb[$];

  int m_samp, m_sym, m_mis, m_cur, m_max;
  bit m_sat, m_err, m_valid;

  always #5 clk = ~clk;

  symmetry_stats #(.WINDOW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sym(in_sym),
    .in_mismatch(in_mismatch), .clear(clear), .rd_sel(rd_sel),
    .rd_data(rd_data), .win_done(win_done), .busy(busy)
  );

  symmetry_stats #(.WINDOW(255)) dut255 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sym(in_sym),
    .in_mismatch(in_mismatch), .clear(clear), .rd_sel(rd_sel),
    .rd_data(rd_data2), .win_done(win_done2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_samp = 0; m_sym = 0; m_mis = 0; m_cur = 0; m_max = 0;
    m_sat = 0; m_err = 0; m_valid = 0;
  endtask

  task automatic model_sample(input bit s, input int mis);
    int sum;
    m_samp++;
    sum = m_mis + mis;
    if (sum > 255) begin m_mis = 255; m_sat = 1; end
    else m_mis = sum;
    if ((s && mis != 0) || (!s && mis == 0) || mis > 4) m_err = 1;
    if (s) begin
      m_sym++;
      m_cur++;
      if (m_cur > m_max) m_max = m_cur;
    end else m_cur = 0;
    if (m_samp == 16) begin
      sb.push_back('{8'(m_sym), 8'(m_mis), 8'(m_max)});
      m_samp = 0; m_sym = 0; m_mis = 0; m_cur = 0; m_max = 0;
      m_valid = 1;
    end
  endtask

  function automatic logic [7:0] exp_stat();
    return {4'b0, m_err, m_sat, m_samp != 0, m_valid};
  endfunction

  task automatic send(input bit s, input int mis);
    @(negedge clk);
    in_valid = 1'b1;
    in_sym = s;
    in_mismatch = 3'(mis);
    model_sample(s, mis);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_sym = 1'b0;
    in_mismatch = 3'd0;
    clear = 1'b0;
  endtask

  task automatic rd(input logic [1:0] sel, output logic [7:0] v,
                    output logic [7:0] v2);
    @(negedge clk);
    rd_sel = sel;
    @(posedge clk);
    #1;
    v = rd_data;
    v2 = rd_data2;
  endtask

  task automatic finish_window(input string tag);
    exp_t e;
    logic [7:0] v, v2;
    idle();
    chk({tag, "_done"}, 8'(win_done), 8'd1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 8'(win_done), 8'd0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 8'd1, 8'd0);
      return;
    end
    e = sb.pop_front();
    rd(2'd0, v, v2); chk({tag, "_sym"}, v, e.sym);
    rd(2'd1, v, v2); chk({tag, "_mis"}, v, e.mis);
    rd(2'd2, v, v2); chk({tag, "_run"}, v, e.run);
    rd(2'd3, v, v2); chk({tag, "_stat"}, v, exp_stat());
  endtask

  initial begin
    logic [7:0] v, v2;
    int cnt;
    rst_n = 1'b0;
    in_valid = 1'b0; in_sym = 1'b0; in_mismatch = 3'd0;
    clear = 1'b0; rd_sel = 2'd0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_rd", rd_data, 8'h00);
    chk("rst_done", 8'(win_done), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_busy255", 8'(busy2), 8'd0);
    rst_n = 1'b1;
    rd(2'd3, v, v2);
    chk("rst_stat", v, 8'h00);

    // Full symmetric window
    for (int i = 0; i < 16; i++) begin
      send(1, 0);
      if (i == 0) begin
        @(negedge clk);
        in_valid = 1'b0;
        chk("first_busy", 8'(busy), 8'd1);
      end
    end
    finish_window("full");
    chk("full_stat_lit", v, 8'h00);

    // Alternating sym / asym with mismatch 2
    for (int i = 0; i < 16; i++) send(i % 2 == 0, (i % 2 == 0) ? 0 : 2);
    finish_window("alt");

    // Run across a window boundary, back-to-back into next window
    send(0, 1);
    repeat (5) send(1, 0);
    send(0, 1);
    repeat (9) send(1, 0);
    send(1, 0);
    chk("bnd_done", 8'(win_done), 8'd1);
    chk("bnd_busy_gap", 8'(busy), 8'd0);
    send(1, 0);
    chk("bnd_busy_back", 8'(busy), 8'd1);
    chk("bnd_done_low", 8'(win_done), 8'd0);
    send(1, 0);
    if (sb.size() == 0) chk("bnd_sb", 8'd1, 8'd0);
    else begin
      exp_t e;
      e = sb.pop_front();
      chk("bnd_exp_run9", e.run, 8'd9);
      idle();
      rd(2'd2, v, v2);
      chk("bnd_run", v, e.run);
      rd(2'd0, v, v2);
      chk("bnd_sym", v, e.sym);
    end
    repeat (13) send(0, 1);
    finish_window("bnd2");

    // Consistency error: sym with mismatch 3
    send(1, 3);
    repeat (15) send(1, 0);
    finish_window("err");

    // Clear together with a valid sample mid-window
    repeat (7) send(1, 0);
    @(negedge clk);
    in_valid = 1'b1; in_sym = 1'b1; in_mismatch = 3'd0;
    clear = 1'b1;
    model_clear();
    idle();
    chk("clr_busy", 8'(busy), 8'd0);
    rd(2'd3, v, v2);
    chk("clr_stat", v, 8'h00);
    rd(2'd0, v, v2);
    chk("clr_sym", v, 8'h00);
    repeat (15) send(1, 0);
    idle();
    chk("clr_no_early", 8'(win_done), 8'd0);
    chk("clr_busy15", 8'(busy), 8'd1);
    send(1, 0);
    finish_window("clr");

    // Reset pulsed mid-window
    repeat (7) send(0, 2);
    idle();
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("mrst_busy", 8'(busy), 8'd0);
    chk("mrst_done", 8'(win_done), 8'd0);
    chk("mrst_rd", rd_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    rd(2'd3, v, v2);
    chk("mrst_stat", v, 8'h00);
    for (int i = 0; i < 16; i++) send(i < 4, (i < 4) ? 0 : 1);
    finish_window("mrst");

    // Saturation on the 255-sample instance
    @(negedge clk);
    clear = 1'b1;
    idle();
    model_clear();
    repeat (255) send(0, 4);
    idle();
    cnt = 0;
    while (win_done2 !== 1'b1 && cnt < 4) begin
      @(negedge clk);
      cnt++;
    end
    chk("sat_done", 8'(win_done2), 8'd1);
    rd(2'd1, v, v2);
    chk("sat_mis", v2, 8'd255);
    rd(2'd3, v, v2);
    chk("sat_stat", v2, 8'h05);
    send(0, 1);
    idle();
    rd(2'd3, v, v2);
    chk("sat_sticky", v2, 8'h07);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
